// File: rtl/fmi_tile_ctrl.sv
// Sequencer for the single-port FM-input tile RAM: streams a tile in from the loader,
// then serves fixed one-cycle-latency compute reads until the tile is released.
module fmi_tile_ctrl #(
  parameter int FMI_N_ELEM = 1024,
  parameter int PX_W       = 16,
  parameter int ADDR_W     = $clog2(FMI_N_ELEM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_elem,
  input  logic              ld_valid,
  input  logic [PX_W-1:0]   ld_data,
  output logic              ld_ready,
  output logic              tile_rdy,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [PX_W-1:0]   rd_data,
  input  logic              release_t,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PX_W-1:0]   ram_data,
  output logic              ram_write,
  input  logic [PX_W-1:0]   ram_res
);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

  localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(FMI_N_ELEM);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] count_reg, count_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic              rd_valid_reg, rd_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      len_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    rd_valid_next = 1'b0;
    ld_ready      = 1'b0;
    tile_rdy      = 1'b0;
    ram_addr      = '0;
    ram_data      = '0;
    ram_write     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          count_next = '0;
          if (n_elem == '0) begin
            // Empty tile: nothing to load, go straight to serving.
            len_next   = '0;
            state_next = SERVE;
          end else begin
            len_next   = (n_elem > MAX_LEN) ? MAX_LEN : n_elem;
            state_next = LOAD;
          end
        end
      end

      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ram_write = 1'b1;
          ram_addr  = count_reg;
          ram_data  = ld_data;
          if (count_reg == len_reg - ADDR_W'(1)) begin
            count_next = '0;
            state_next = SERVE;
          end else begin
            count_next = count_reg + ADDR_W'(1);
          end
        end
      end

      SERVE: begin
        tile_rdy = 1'b1;
        // A read issued together with release_t still completes next cycle.
        if (rd_req) begin
          ram_addr      = rd_addr;
          rd_valid_next = 1'b1;
        end
        if (release_t) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_valid_reg ? ram_res : '0;

endmodule

// File: tb/tb_fmi_tile_ctrl.sv
// Directed testbench for fmi_tile_ctrl with a behavioural write-first sync-read RAM.
module tb_fmi_tile_ctrl;
  localparam int N      = 1024;
  localparam int PX_W   = 16;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] n_elem = '0;
  logic              ld_valid = 1'b0;
  logic [PX_W-1:0]   ld_data = '0;
  logic              ld_ready;
  logic              tile_rdy;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [PX_W-1:0]   rd_data;
  logic              release_t = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [PX_W-1:0]   ram_data;
  logic              ram_write;
  logic [PX_W-1:0]   ram_res = '0;

  logic [PX_W-1:0] mem [0:N-1];
  int wr_addr_q[$];
  int wr_data_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmi_tile_ctrl #(.FMI_N_ELEM(N), .PX_W(PX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_elem(n_elem),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .tile_rdy(tile_rdy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .release_t(release_t), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_write(ram_write), .ram_res(ram_res)
  );

  // Write-first RAM model plus per-transaction log.
  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_addr[9:0]] <= ram_data;
      ram_res <= ram_data;
      wr_addr_q.push_back(int'(ram_addr));
      wr_data_q.push_back(int'(ram_data));
      $display("wr addr=%0d data=%h", ram_addr, ram_data);
    end else begin
      ram_res <= mem[ram_addr[9:0]];
    end
    if (rd_valid) $display("rd data=%h", rd_data);
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic start_tile(input int n);
    @(negedge clk);
    start = 1'b1;
    n_elem = ADDR_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_tile();
    @(negedge clk);
    release_t = 1'b1;
    @(negedge clk);
    release_t = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b1; ld_data = 16'hFFFF; rd_req = 1'b1; rd_addr = 11'd7;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({ld_ready, tile_rdy, rd_valid, ram_write} !== 4'b0)
      $display("FAIL reset_ctrl: got %b expected 0000", {ld_ready, tile_rdy, rd_valid, ram_write});
    checks++;
    if (ram_addr !== '0 || ram_data !== '0 || rd_data !== '0)
      $display("FAIL reset_data: got addr=%h data=%h rd=%h expected 0", ram_addr, ram_data, rd_data);
    if ({ld_ready, tile_rdy, rd_valid, ram_write} !== 4'b0 || ram_addr !== '0 || ram_data !== '0 || rd_data !== '0)
      errors++;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ld_ready !== 1'b0 || ram_write !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got ready=%b wr=%b rv=%b expected 0 0 0", ld_ready, ram_write, rd_valid);
    end
    ld_valid = 1'b0; rd_req = 1'b0;
  endtask

  task automatic test_load4();
    clear_log();
    start_tile(4);
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 16'((i + 1) * 17);
      #1;
      checks++;
      if (ld_ready !== 1'b1 || ram_write !== 1'b1 || ram_addr !== ADDR_W'(i) || ram_data !== 16'((i + 1) * 17)) begin
        errors++;
        $display("FAIL load4_wr%0d: got rdy=%b wr=%b addr=%0d data=%h expected 1 1 %0d %h",
                 i, ld_ready, ram_write, ram_addr, ram_data, i, 16'((i + 1) * 17));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ld_ready !== 1'b0 || ram_write !== 1'b0 || tile_rdy !== 1'b1) begin
      errors++;
      $display("FAIL load4_done: got rdy=%b wr=%b tile=%b expected 0 0 1", ld_ready, ram_write, tile_rdy);
    end
    ld_valid = 1'b0;
    rd_req = 1'b1; rd_addr = 11'd2;
    #1;
    checks++;
    if (ram_addr !== 11'd2 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL load4_rdaddr: got addr=%0d wr=%b expected 2 0", ram_addr, ram_write);
    end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h0033) begin
      errors++;
      $display("FAIL load4_read: got rv=%b data=%h expected 1 0033", rd_valid, rd_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL load4_rv_drop: got %b expected 0", rd_valid);
    end
    release_tile();
  endtask

  task automatic test_stall();
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_log();
    start_tile(3);
    for (int i = 0; i < 6; i++) begin
      ld_valid = pat[i];
      ld_data = 16'(16'hA0 + i);
      #1;
      checks++;
      if (ram_write !== pat[i]) begin
        errors++;
        $display("FAIL stall_wr%0d: got %b expected %b", i, ram_write, pat[i]);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    checks++;
    if (tile_rdy !== 1'b1 || wr_addr_q.size() != 3) begin
      errors++;
      $display("FAIL stall_count: got tile=%b writes=%0d expected 1 3", tile_rdy, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] != 0 || wr_addr_q[1] != 1 || wr_addr_q[2] != 2 ||
          wr_data_q[0] != 'hA0 || wr_data_q[1] != 'hA3 || wr_data_q[2] != 'hA5) begin
        errors++;
        $display("FAIL stall_seq: got %0d/%h %0d/%h %0d/%h expected 0/a0 1/a3 2/a5",
                 wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], wr_addr_q[2], wr_data_q[2]);
      end
    end
  endtask

  // Runs in SERVE on the tile left by test_stall (a0, a3, a5).
  task automatic test_back_to_back();
    int addrs [4];
    logic [PX_W-1:0] exp [4];
    addrs = '{0, 1, 2, 0};
    exp = '{16'h00A0, 16'h00A3, 16'h00A5, 16'h00A0};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        rd_req = 1'b1; rd_addr = ADDR_W'(addrs[i]);
      end else begin
        rd_req = 1'b0;
      end
      #1;
      if (i > 0) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp[i-1]) begin
          errors++;
          $display("FAIL b2b_rd%0d: got rv=%b data=%h expected 1 %h", i - 1, rd_valid, rd_data, exp[i-1]);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got rv=%b expected 0", rd_valid);
    end
    rd_req = 1'b1; rd_addr = 11'd1; release_t = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; release_t = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h00A3 || tile_rdy !== 1'b0) begin
      errors++;
      $display("FAIL release_rd: got rv=%b data=%h tile=%b expected 1 00a3 0", rd_valid, rd_data, tile_rdy);
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_load();
    clear_log();
    start_tile(4);
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 16'(16'h21 + i);
      start = (i == 2);
      n_elem = (i == 2) ? 11'd8 : 11'd4;
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    checks++;
    if (tile_rdy !== 1'b1 || ld_ready !== 1'b0 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: got tile=%b rdy=%b wr=%b expected 1 0 0", tile_rdy, ld_ready, ram_write);
    end
    @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != 4) begin
      errors++;
      $display("FAIL restart_count: got %0d writes expected 4", wr_addr_q.size());
    end
    release_tile();
  endtask

  task automatic test_reset_mid();
    start_tile(4);
    ld_valid = 1'b1; ld_data = 16'h0031;
    @(negedge clk);
    ld_data = 16'h0032;
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({ld_ready, tile_rdy, rd_valid, ram_write} !== 4'b0 || ram_addr !== '0 || ram_data !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL midrst_out: got rdy=%b tile=%b rv=%b wr=%b addr=%h expected all 0",
               ld_ready, tile_rdy, rd_valid, ram_write, ram_addr);
    end
    clear_log();
    start_tile(2);
    ld_valid = 1'b1;
    ld_data = 16'h0055;
    @(negedge clk);
    ld_data = 16'h0066;
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    checks++;
    if (tile_rdy !== 1'b1 || wr_addr_q.size() != 2) begin
      errors++;
      $display("FAIL midrst_reload: got tile=%b writes=%0d expected 1 2", tile_rdy, wr_addr_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] != 0 || wr_addr_q[1] != 1 || wr_data_q[1] != 'h66) begin
        errors++;
        $display("FAIL midrst_addrs: got %0d %0d data1=%h expected 0 1 66", wr_addr_q[0], wr_addr_q[1], wr_data_q[1]);
      end
    end
    // Reset together with a read: the read must not complete.
    rd_req = 1'b1; rd_addr = 11'd0; rst = 1'b1;
    @(negedge clk);
    rd_req = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || tile_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rst_read: got rv=%b tile=%b expected 0 0", rd_valid, tile_rdy);
    end
  endtask

  task automatic test_bounds();
    int k;
    clear_log();
    start_tile(0);
    ld_valid = 1'b1;
    #1;
    checks++;
    if (tile_rdy !== 1'b1 || ld_ready !== 1'b0 || ram_write !== 1'b0) begin
      errors++;
      $display("FAIL empty_tile: got tile=%b rdy=%b wr=%b expected 1 0 0", tile_rdy, ld_ready, ram_write);
    end
    ld_valid = 1'b0;
    release_tile();
    start_tile(N + 5);
    ld_valid = 1'b1;
    k = 0;
    while (tile_rdy !== 1'b1 && k < 1100) begin
      ld_data = 16'(16'h1000 + k);
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ld_ready !== 1'b0 || wr_addr_q.size() != N) begin
      errors++;
      $display("FAIL clamp_count: got rdy=%b writes=%0d expected 0 %0d", ld_ready, wr_addr_q.size(), N);
    end else begin
      checks++;
      if (wr_addr_q[N-1] != N - 1 || wr_data_q[N-1] != 'h13FF) begin
        errors++;
        $display("FAIL clamp_last: got addr=%0d data=%h expected 1023 13ff", wr_addr_q[N-1], wr_data_q[N-1]);
      end
    end
    ld_valid = 1'b0;
    rd_req = 1'b1; rd_addr = 11'd1023;
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h13FF) begin
      errors++;
      $display("FAIL clamp_read: got rv=%b data=%h expected 1 13ff", rd_valid, rd_data);
    end
    release_tile();
    #1;
    checks++;
    if (tile_rdy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got tile=%b expected 0", tile_rdy);
    end
    rd_req = 1'b1; rd_addr = 11'd5;
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL idle_read: got rv=%b data=%h expected 0 0000", rd_valid, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_stall();
    test_back_to_back();
    test_start_in_load();
    test_reset_mid();
    test_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
